// File: rtl/ddsm_div_ctrl.sv
// Divider controller: turns DDSM fractional words plus an integer divide value into
// divider pulses of exactly N+frac clocks. Optional macro: DDSM_DIV_DUTY50_EN (square-wave output).
module ddsm_div_ctrl #(
    parameter int unsigned P_INT_W     = 8,
    parameter int unsigned P_MIN_RATIO = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_en,
    input  logic [P_INT_W-1:0] i_int,
    input  logic [3:0]         i_frac,
    input  logic               i_frac_vld,
    output logic               o_frac_rdy,
    output logic               o_div_pulse,
    output logic [P_INT_W-1:0] o_ratio,
    output logic               o_sat,
    output logic               o_underrun
);

    localparam int unsigned SUM_W = P_INT_W + 2;
    localparam logic [P_INT_W-1:0] MIN_R = P_INT_W'(P_MIN_RATIO);
    localparam logic [P_INT_W-1:0] MAX_R = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRIME = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic               buf_full_q, buf_full_d;
    logic [P_INT_W-1:0] buf_r_q, buf_r_d;
    logic [P_INT_W-1:0] last_int_q, last_int_d;
    logic [P_INT_W-1:0] cnt_q, cnt_d;
    logic [P_INT_W-1:0] ratio_q, ratio_d;
    logic               pulse_q, pulse_d;
    logic               rdy_q, rdy_d;
    logic               sat_q, sat_d;
    logic               und_q, und_d;
    logic               stop_q, stop_d;

    logic                    accept_c;
    logic                    tc_c;
    logic signed [SUM_W-1:0] sum_c;
    logic [P_INT_W-1:0]      acc_r_c;
    logic                    acc_sat_c;
    logic [P_INT_W-1:0]      und_r_c;
    logic                    und_sat_c;

    assign accept_c = i_frac_vld && rdy_q;
    assign tc_c     = (state_q == S_RUN) && (cnt_q == '0);

    // Ratio of an incoming sample, clamped into [P_MIN_RATIO, 2^P_INT_W-1]
    always_comb begin
        sum_c     = $signed({2'b00, i_int}) + $signed({{(SUM_W-4){i_frac[3]}}, i_frac});
        acc_r_c   = sum_c[P_INT_W-1:0];
        acc_sat_c = 1'b0;
        if (sum_c < $signed(SUM_W'(P_MIN_RATIO))) begin
            acc_r_c   = MIN_R;
            acc_sat_c = 1'b1;
        end else if (sum_c > $signed({2'b00, MAX_R})) begin
            acc_r_c   = MAX_R;
            acc_sat_c = 1'b1;
        end
    end

    // Underrun reload repeats the last integer with a zero fraction
    always_comb begin
        und_r_c   = last_int_q;
        und_sat_c = 1'b0;
        if (last_int_q < MIN_R) begin
            und_r_c   = MIN_R;
            und_sat_c = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A disable seen at any point of the period takes effect at its terminal count
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (i_en) state_d = S_PRIME;
            S_PRIME: begin
                if (!i_en) begin
                    state_d = S_IDLE;
                end else if (buf_full_q) begin
                    state_d = S_RUN;
                end
            end
            S_RUN:   if (tc_c && (stop_q || !i_en)) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        buf_full_d = buf_full_q;
        buf_r_d    = buf_r_q;
        last_int_d = last_int_q;
        cnt_d      = cnt_q;
        ratio_d    = ratio_q;
        sat_d      = sat_q;
        und_d      = und_q;
        stop_d     = stop_q;

        if (accept_c) begin
            buf_full_d = 1'b1;
            buf_r_d    = acc_r_c;
            last_int_d = i_int;
            if (acc_sat_c) sat_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (state_d == S_PRIME) begin
                    sat_d = 1'b0;
                    und_d = 1'b0;
                end
            end
            S_PRIME: begin
                if (state_d == S_RUN) begin
                    cnt_d      = buf_r_q - P_INT_W'(1);
                    ratio_d    = buf_r_q;
                    buf_full_d = 1'b0;
                end
            end
            S_RUN: begin
                if (!i_en) stop_d = 1'b1;
                if (!tc_c) begin
                    cnt_d = cnt_q - P_INT_W'(1);
                end else if (state_d == S_RUN) begin
                    if (buf_full_q) begin
                        cnt_d      = buf_r_q - P_INT_W'(1);
                        ratio_d    = buf_r_q;
                        buf_full_d = 1'b0;
                    end else begin
                        // A sample accepted this cycle stays buffered for the next TC
                        cnt_d   = und_r_c - P_INT_W'(1);
                        ratio_d = und_r_c;
                        und_d   = 1'b1;
                        if (und_sat_c) sat_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase

        if (state_d == S_IDLE) begin
            buf_full_d = 1'b0;
            cnt_d      = '0;
            stop_d     = 1'b0;
        end

        rdy_d = (state_d != S_IDLE) && !buf_full_d;
`ifdef DDSM_DIV_DUTY50_EN
        pulse_d = (state_d == S_RUN) &&
                  ({1'b0, cnt_d} >= (({1'b0, ratio_d} + (P_INT_W+1)'(1)) >> 1));
`else
        pulse_d = (state_d == S_RUN) && (cnt_d == '0);
`endif
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            buf_full_q <= 1'b0;
            buf_r_q    <= '0;
            last_int_q <= '0;
            cnt_q      <= '0;
            ratio_q    <= '0;
            pulse_q    <= 1'b0;
            rdy_q      <= 1'b0;
            sat_q      <= 1'b0;
            und_q      <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            buf_full_q <= buf_full_d;
            buf_r_q    <= buf_r_d;
            last_int_q <= last_int_d;
            cnt_q      <= cnt_d;
            ratio_q    <= ratio_d;
            pulse_q    <= pulse_d;
            rdy_q      <= rdy_d;
            sat_q      <= sat_d;
            und_q      <= und_d;
            stop_q     <= stop_d;
        end
    end

    assign o_frac_rdy  = rdy_q;
    assign o_div_pulse = pulse_q;
    assign o_ratio     = ratio_q;
    assign o_sat       = sat_q;
    assign o_underrun  = und_q;

endmodule

// File: tb/tb_ddsm_div_ctrl.sv
// Self-checking bench for ddsm_div_ctrl: expected period ratios are queued when samples
// are driven and checked against each divider pulse (ratio and pulse-to-pulse interval).
module tb_ddsm_div_ctrl;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic       i_en;
    logic [7:0] i_int;
    logic [3:0] i_frac;
    logic       i_frac_vld;
    logic       o_frac_rdy;
    logic       o_div_pulse;
    logic [7:0] o_ratio;
    logic       o_sat;
    logic       o_underrun;

    int errors = 0;
    int checks = 0;
    int exp_q[$];
    int cyc = 0;
    int last_pulse = 0;
    bit skip_iv = 1'b1;

    ddsm_div_ctrl #(.P_INT_W(8), .P_MIN_RATIO(4)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_en       (i_en),
        .i_int      (i_int),
        .i_frac     (i_frac),
        .i_frac_vld (i_frac_vld),
        .o_frac_rdy (o_frac_rdy),
        .o_div_pulse(o_div_pulse),
        .o_ratio    (o_ratio),
        .o_sat      (o_sat),
        .o_underrun (o_underrun)
    );

    initial forever #5 i_clk = ~i_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input int obs, input int exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic int model_ratio(input int a, input int f);
        int r;
        r = a + f;
        if (r < 4) r = 4;
        if (r > 255) r = 255;
        return r;
    endfunction

    // Pulse monitor: each pulse consumes one expected period ratio
    task automatic monitor();
        int e;
        forever begin
            @(negedge i_clk);
            cyc++;
            if (o_div_pulse === 1'b1) begin
                check("pulse_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("ratio", int'(o_ratio), e);
                    if (!skip_iv) check("period", cyc - last_pulse, e);
                end
                skip_iv    = 1'b0;
                last_pulse = cyc;
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic send(input int a, input int f);
        int k;
        k = 0;
        i_int      = 8'(a);
        i_frac     = 4'(f);
        i_frac_vld = 1'b1;
        while (o_frac_rdy !== 1'b1 && k < 2000) begin
            tick(1);
            k++;
        end
        if (o_frac_rdy !== 1'b1) check("send_timeout", int'(o_frac_rdy), 1);
        exp_q.push_back(model_ratio(a, f));
        tick(1);
        i_frac_vld = 1'b0;
    endtask

    task automatic wait_q(input int n, input int limit, input string tag);
        int k;
        k = 0;
        while (exp_q.size() > n && k < limit) begin
            tick(1);
            k++;
        end
        check(tag, exp_q.size(), n);
    endtask

    // Let the last queued period run, drop enable, expect one final pulse then IDLE
    task automatic stop_run(input int extra);
        wait_q(1, 3000, "drain_to_last");
        tick(extra);
        i_en = 1'b0;
        wait_q(0, 3000, "final_pulse");
        check("idle_rdy", int'(o_frac_rdy), 0);
    endtask

    task automatic restart();
        i_en    = 1'b1;
        skip_iv = 1'b1;
        tick(2);
        check("restart_sat_clr", int'(o_sat), 0);
        check("restart_und_clr", int'(o_underrun), 0);
    endtask

    initial begin
        int k;
        i_rst_n    = 1'b0;
        i_en       = 1'b0;
        i_int      = '0;
        i_frac     = '0;
        i_frac_vld = 1'b0;
        fork
            monitor();
        join_none
        tick(2);
        check("rst_pulse", int'(o_div_pulse), 0);
        check("rst_rdy", int'(o_frac_rdy), 0);
        check("rst_ratio", int'(o_ratio), 0);
        check("rst_sat", int'(o_sat), 0);
        check("rst_und", int'(o_underrun), 0);
        i_rst_n = 1'b1;
        tick(1);

        // Steady ratio 20+3
        i_en = 1'b1;
        for (int i = 0; i < 8; i++) send(20, 3);
        check("steady_sat", int'(o_sat), 0);
        check("steady_und", int'(o_underrun), 0);

        // Alternating extreme fractions
        for (int i = 0; i < 100; i++) send(20, (i % 2 == 0) ? -8 : 7);
        stop_run(0);
        check("alt_sat", int'(o_sat), 0);
        check("alt_und", int'(o_underrun), 0);

        // Low clamp
        restart();
        for (int i = 0; i < 3; i++) send(6, -8);
        stop_run(0);
        check("low_clamp_sat", int'(o_sat), 1);

        // High clamp
        restart();
        for (int i = 0; i < 2; i++) send(255, 7);
        stop_run(0);
        check("high_clamp_sat", int'(o_sat), 1);
        check("high_clamp_und", int'(o_underrun), 0);

        // Underrun: two starved TCs, then a sample presented on a TC cycle
        restart();
        send(20, 0);
        exp_q.push_back(20);
        exp_q.push_back(20);
        wait_q(1, 3000, "underrun_two");
        k = 0;
        while (o_div_pulse !== 1'b1 && k < 100) begin
            tick(1);
            k++;
        end
        check("underrun_tc_seen", int'(o_div_pulse), 1);
        check("underrun_tc_rdy", int'(o_frac_rdy), 1);
        exp_q.push_back(20);
        exp_q.push_back(25);
        i_int      = 8'd25;
        i_frac     = 4'd0;
        i_frac_vld = 1'b1;
        tick(1);
        i_frac_vld = 1'b0;
        check("underrun_flag", int'(o_underrun), 1);
        check("underrun_held", int'(o_frac_rdy), 0);
        stop_run(0);
        check("underrun_sticky", int'(o_underrun), 1);

        // Disable mid-period of ratio 30
        restart();
        send(30, 0);
        send(30, 0);
        stop_run(10);
        tick(60);
        check("disabled_no_pulse", int'(o_div_pulse), 0);
        check("disabled_rdy", int'(o_frac_rdy), 0);

        // Reset for one cycle mid-count, then restart with ratio 10
        restart();
        send(20, 0);
        tick(8);
        i_rst_n = 1'b0;
        tick(1);
        i_rst_n = 1'b1;
        exp_q.delete();
        skip_iv = 1'b1;
        check("midrst_pulse", int'(o_div_pulse), 0);
        check("midrst_rdy", int'(o_frac_rdy), 0);
        check("midrst_ratio", int'(o_ratio), 0);
        check("midrst_sat", int'(o_sat), 0);
        check("midrst_und", int'(o_underrun), 0);
        for (int i = 0; i < 3; i++) send(10, 0);
        stop_run(0);
        check("midrst_final_ratio", int'(o_ratio), 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
